serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder. Operands are processed LSB-first, one bit per clock.
- Datapath is one full-adder cell built from two existing half_adder instances plus a registered carry.
- It is the sequential consumer of the half_adder cell: it turns the combinational s/c outputs into a multi-bit sum over WIDTH cycles.
- Used where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder.sv | 33 +++
 rtl/half_adder.sv | 15 +
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants and helpers for the serial_adder slice.
//   WIDTH limits : legal operand widths for serial_adder
//   cnt_width()  : bit-count width for the serial step counter
package serial_adder_pkg;

  localparam int unsigned SA_WIDTH_MIN = 2;
  localparam int unsigned SA_WIDTH_MAX = 32;

  // Counter width covering 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Full-adder cell built from two half_adder instances.
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry-out (majority of a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (cin),
    .s (s),
    .c (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Half-adder cell.
//   a, b : input bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder, LSB first, one bit per clock.
//   clk, rst_n : clock, async active-low reset
//   start      : request, sampled only in IDLE; a/b captured on acceptance
//   a, b       : operands
//   busy       : high while bits are processed
//   done       : one-cycle pulse when sum/cout become valid
//   sum, cout  : registered result, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_width_chk
    $error("serial_adder: WIDTH out of range");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-2:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] ps_shift;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // New bit enters at the MSB; ps keeps only the upper WIDTH-1 bits since
  // the final bit goes straight into sum.
  assign ps_shift = {fa_s, ps_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values.
  always_comb begin
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          ps_d    = '0;
        end
      end
      S_RUN: begin
        carry_d = fa_co;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        ps_d    = ps_shift[WIDTH-1:1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d  = ps_shift;
          cout_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=4).
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_chk;
  int n_pass;
  int done8_cnt;
  int done4_cnt;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done8 === 1'b1) done8_cnt++;
    if (done4 === 1'b1) done4_cnt++;
  end

  task automatic pulse_start8(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_done4(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL reset_asserted8: got %b want 0", {busy8, done8, cout8, sum8});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL reset_released8: got %b want 0", {busy8, done8, cout8, sum8});
    else n_pass++;
    n_chk++;
    if ({busy4, done4, cout4, sum4} !== 7'd0)
      $display("FAIL reset_released4: got %b want 0", {busy4, done4, cout4, sum4});
    else n_pass++;
  endtask

  task automatic test_basic();
    pulse_start8(8'd3, 8'd5);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_chk++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'd0)
        $display("FAIL basic_run cycle %0d: busy=%b done=%b sum=%h want busy=1 done=0 sum=00",
                 i, busy8, done8, sum8);
      else n_pass++;
    end
    @(negedge clk);
    n_chk++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== 8'd8 || cout8 !== 1'b0)
      $display("FAIL basic_done: done=%b busy=%b sum=%h cout=%b want 1 0 08 0",
               done8, busy8, sum8, cout8);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (done8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL basic_after: done=%b busy=%b want 0 0", done8, busy8);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit got;
    pulse_start8(8'hFF, 8'h01);
    wait_done8(got);
    n_chk++;
    if (!got || sum8 !== 8'h00 || cout8 !== 1'b1)
      $display("FAIL carry_ff01: got=%b sum=%h cout=%b want 1 00 1", got, sum8, cout8);
    else n_pass++;
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy8, done8);
    else n_pass++;
    @(negedge clk);
    start8 = 1'b0;
    n_chk++;
    if (busy8 !== 1'b1)
      $display("FAIL b2b_accept: busy=%b want 1", busy8);
    else n_pass++;
    wait_done8(got);
    n_chk++;
    if (!got || sum8 !== 8'hFE || cout8 !== 1'b1)
      $display("FAIL carry_ffff: got=%b sum=%h cout=%b want 1 fe 1", got, sum8, cout8);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    bit got;
    int d0;
    repeat (2) @(negedge clk);
    d0 = done8_cnt;
    pulse_start8(8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    a8 = 8'h11;
    b8 = 8'h11;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(got);
    n_chk++;
    if (!got || sum8 !== 8'hFF || cout8 !== 1'b0)
      $display("FAIL ignore_result: got=%b sum=%h cout=%b want 1 ff 0", got, sum8, cout8);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_chk++;
    if (done8_cnt - d0 !== 1 || busy8 !== 1'b0)
      $display("FAIL ignore_pulses: dones=%0d busy=%b want 1 0", done8_cnt - d0, busy8);
    else n_pass++;
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (sum8 !== 8'hFF || cout8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0)
      $display("FAIL hold: %0d bad cycles, last sum=%h cout=%b done=%b want ff 0 0",
               bad, sum8, cout8, done8);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit got;
    int d0;
    pulse_start8(8'h3C, 8'h0F);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL midrun_async: got %b want 0", {busy8, done8, cout8, sum8});
    else n_pass++;
    d0 = done8_cnt;
    repeat (3) @(negedge clk);
    n_chk++;
    if (done8_cnt != d0 || {busy8, done8, cout8, sum8} !== 11'd0)
      $display("FAIL midrun_held: dones=%0d outs=%b want 0 0", done8_cnt - d0,
               {busy8, done8, cout8, sum8});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (done8_cnt != d0 || busy8 !== 1'b0)
      $display("FAIL midrun_release: dones=%0d busy=%b want 0 0", done8_cnt - d0, busy8);
    else n_pass++;
    pulse_start8(8'd7, 8'd9);
    wait_done8(got);
    n_chk++;
    if (!got || sum8 !== 8'd16 || cout8 !== 1'b0)
      $display("FAIL after_reset: got=%b sum=%h cout=%b want 1 10 0", got, sum8, cout8);
    else n_pass++;
  endtask

  task automatic test_exhaustive4();
    bit got;
    int d0;
    logic [4:0] expv;
    d0 = done4_cnt;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        a4 = 4'(i);
        b4 = 4'(j);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(got);
        expv = 5'(i) + 5'(j);
        n_chk++;
        if (!got || {cout4, sum4} !== expv)
          $display("FAIL w4 %0d+%0d: got=%b result=%h want %h", i, j, got, {cout4, sum4}, expv);
        else n_pass++;
      end
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (done4_cnt - d0 != 256)
      $display("FAIL w4_done_count: got %0d want 256", done4_cnt - d0);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    done8_cnt = 0;
    done4_cnt = 0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start4 = 1'b0;
    a4 = '0;
    b4 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_hold();
    test_reset_mid_run();
    test_exhaustive4();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
